alu_exec_unit: RTL

- Execute-stage ALU. Consumes the 4-bit alufn code from the ALU control decoder and the two 32-bit operands, and produces a registered result plus branch flags.
- Logic and arithmetic ops complete in one cycle.
- Shifts use an iterative barrel-free shifter of SHIFT_STEP bits per cycle, under a start/busy/valid handshake.
- The unit sits between operand select and writeback/branch compare; the core stalls on busy.

---
 rtl/alu_exec_unit.sv | 306 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_exec_unit.sv
// ---------------------------------------------------------------------------
// alu_exec_unit
//
// Execute-stage ALU. Logic and arithmetic operations complete in a single
// edge; shifts run on an iterative shifter that moves SHIFT_STEP bits per
// cycle under a start/busy/valid handshake. The result and the branch flags
// are registered and hold their value between completions.
//
// Parameters:
//   XLEN       - operand/result width, fixed at 32 (shift amount is b[4:0])
//   SHIFT_STEP - bits shifted per SHIFT cycle: 1, 2, 4 or 8
//
// Ports:
//   clk       in   1     rising-edge clock
//   rst_n     in   1     asynchronous active-low reset
//   i_start   in   1     operation request, sampled only in IDLE
//   i_alufn   in   4     operation code from ALU control
//   i_a       in   XLEN  operand A
//   i_b       in   XLEN  operand B (b[4:0] = shift amount for shifts)
//   o_result  out  XLEN  registered result, held until next completion
//   o_valid   out  1     one-cycle pulse when result/flags update
//   o_busy    out  1     high while a shift is in progress
//   o_zf      out  1     result == 0
//   o_sf      out  1     result[31]
//   o_cf      out  1     carry (ADD) / not-borrow (SUB), else 0
//   o_vf      out  1     signed overflow (ADD/SUB), else 0
// ---------------------------------------------------------------------------
module alu_exec_unit #(
    parameter int XLEN       = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_start,
    input  logic [3:0]      i_alufn,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic [XLEN-1:0] o_result,
    output logic            o_valid,
    output logic            o_busy,
    output logic            o_zf,
    output logic            o_sf,
    output logic            o_cf,
    output logic            o_vf
);

    // Only the documented configurations are buildable.
    generate
        if (XLEN != 32) begin : g_bad_xlen
            $error("alu_exec_unit: XLEN must be 32");
        end
        if (!((SHIFT_STEP == 1) || (SHIFT_STEP == 2) ||
              (SHIFT_STEP == 4) || (SHIFT_STEP == 8))) begin : g_bad_step
            $error("alu_exec_unit: SHIFT_STEP must be 1, 2, 4 or 8");
        end
    endgenerate

    // Operation codes
    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_PASS = 4'b0011;
    localparam logic [3:0] OP_OR   = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_XOR  = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;
    localparam logic [3:0] OP_SLT  = 4'b1101;
    localparam logic [3:0] OP_SLTU = 4'b1111;

    // Internal shift-kind encoding latched at shift start
    localparam logic [1:0] SH_SLL = 2'd0;
    localparam logic [1:0] SH_SRL = 2'd1;
    localparam logic [1:0] SH_SRA = 2'd2;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_next_state;

    // Shift datapath state
    logic [XLEN-1:0]   r_sh_val;
    logic [4:0]        r_sh_cnt;
    logic [1:0]        r_sh_op;
    logic              r_sh_fill;

    // Output registers
    logic [XLEN-1:0]   r_result;
    logic              r_valid;
    logic              r_busy;
    logic              r_zf;
    logic              r_sf;
    logic              r_cf;
    logic              r_vf;

    // Combinational signals
    logic [XLEN:0]     w_sum_add;
    logic [XLEN:0]     w_sum_sub;
    logic [XLEN-1:0]   w_alu_result;
    logic              w_alu_cf;
    logic              w_alu_vf;
    logic              w_is_shift;
    logic [4:0]        w_shamt;
    logic [1:0]        w_load_op;
    logic [XLEN-1:0]   w_shift_val;
    logic [4:0]        w_shift_cnt;
    logic              w_load;
    logic              w_done;
    logic [XLEN-1:0]   w_done_result;
    logic              w_done_cf;
    logic              w_done_vf;

    // SUB is a + ~b + 1 so bit XLEN is the not-borrow (1 iff a >= b unsigned).
    assign w_sum_add = {1'b0, i_a} + {1'b0, i_b};
    assign w_sum_sub = {1'b0, i_a} + {1'b0, ~i_b} + {{XLEN{1'b0}}, 1'b1};
    assign w_shamt   = i_b[4:0];

    // Shift-op decode and mapping to the internal shift-kind encoding
    always_comb begin
        w_is_shift = 1'b0;
        w_load_op  = SH_SLL;
        case (i_alufn)
            OP_SLL: begin
                w_is_shift = 1'b1;
                w_load_op  = SH_SLL;
            end
            OP_SRL: begin
                w_is_shift = 1'b1;
                w_load_op  = SH_SRL;
            end
            OP_SRA: begin
                w_is_shift = 1'b1;
                w_load_op  = SH_SRA;
            end
            default: begin
                w_is_shift = 1'b0;
                w_load_op  = SH_SLL;
            end
        endcase
    end

    // Single-cycle ALU: result and carry/overflow for every non-iterative op.
    // Shift codes reach here only with a zero shift amount, so they pass a.
    always_comb begin
        w_alu_result = {XLEN{1'b0}};
        w_alu_cf     = 1'b0;
        w_alu_vf     = 1'b0;
        case (i_alufn)
            OP_ADD: begin
                w_alu_result = w_sum_add[XLEN-1:0];
                w_alu_cf     = w_sum_add[XLEN];
                w_alu_vf     = (i_a[XLEN-1] == i_b[XLEN-1]) &&
                               (w_sum_add[XLEN-1] != i_a[XLEN-1]);
            end
            OP_SUB: begin
                w_alu_result = w_sum_sub[XLEN-1:0];
                w_alu_cf     = w_sum_sub[XLEN];
                w_alu_vf     = (i_a[XLEN-1] != i_b[XLEN-1]) &&
                               (w_sum_sub[XLEN-1] != i_a[XLEN-1]);
            end
            OP_PASS: w_alu_result = i_b;
            OP_OR:   w_alu_result = i_a | i_b;
            OP_AND:  w_alu_result = i_a & i_b;
            OP_XOR:  w_alu_result = i_a ^ i_b;
            OP_SLL:  w_alu_result = i_a;
            OP_SRL:  w_alu_result = i_a;
            OP_SRA:  w_alu_result = i_a;
            OP_SLT:  w_alu_result = {{(XLEN-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
            OP_SLTU: w_alu_result = {{(XLEN-1){1'b0}}, (i_a < i_b)};
            default: w_alu_result = {XLEN{1'b0}};
        endcase
    end

    // One SHIFT cycle: up to SHIFT_STEP single-bit moves, stopping when the
    // remaining count runs out so the step is min(SHIFT_STEP, cnt).
    always_comb begin
        w_shift_val = r_sh_val;
        w_shift_cnt = r_sh_cnt;
        for (int i = 0; i < SHIFT_STEP; i++) begin
            if (w_shift_cnt != 5'd0) begin
                case (r_sh_op)
                    SH_SLL:  w_shift_val = {w_shift_val[XLEN-2:0], 1'b0};
                    SH_SRL:  w_shift_val = {1'b0, w_shift_val[XLEN-1:1]};
                    SH_SRA:  w_shift_val = {r_sh_fill, w_shift_val[XLEN-1:1]};
                    default: w_shift_val = w_shift_val;
                endcase
                w_shift_cnt = w_shift_cnt - 5'd1;
            end else begin
                w_shift_val = w_shift_val;
                w_shift_cnt = w_shift_cnt;
            end
        end
    end

    // FSM next state and completion selection
    always_comb begin
        w_next_state  = r_state;
        w_load        = 1'b0;
        w_done        = 1'b0;
        w_done_result = r_result;
        w_done_cf     = 1'b0;
        w_done_vf     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    if (w_is_shift && (w_shamt != 5'd0)) begin
                        w_next_state = ST_SHIFT;
                        w_load       = 1'b1;
                    end else begin
                        w_next_state  = ST_IDLE;
                        w_done        = 1'b1;
                        w_done_result = w_alu_result;
                        w_done_cf     = w_alu_cf;
                        w_done_vf     = w_alu_vf;
                    end
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                // Start is ignored here; only the count decides progress.
                if (w_shift_cnt == 5'd0) begin
                    w_next_state  = ST_IDLE;
                    w_done        = 1'b1;
                    w_done_result = w_shift_val;
                end else begin
                    w_next_state = ST_SHIFT;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Shift datapath: operands latched at start so inputs may change freely
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh_val  <= {XLEN{1'b0}};
            r_sh_cnt  <= 5'd0;
            r_sh_op   <= SH_SLL;
            r_sh_fill <= 1'b0;
        end else if (w_load) begin
            r_sh_val  <= i_a;
            r_sh_cnt  <= w_shamt;
            r_sh_op   <= w_load_op;
            r_sh_fill <= i_a[XLEN-1];
        end else if (r_state == ST_SHIFT) begin
            r_sh_val  <= w_shift_val;
            r_sh_cnt  <= w_shift_cnt;
        end else begin
            r_sh_val  <= r_sh_val;
            r_sh_cnt  <= r_sh_cnt;
        end
    end

    // Result/flag registers, valid pulse and busy indicator
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= {XLEN{1'b0}};
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
            r_zf     <= 1'b1;
            r_sf     <= 1'b0;
            r_cf     <= 1'b0;
            r_vf     <= 1'b0;
        end else begin
            r_valid <= w_done;
            r_busy  <= (w_next_state == ST_SHIFT);
            if (w_done) begin
                r_result <= w_done_result;
                r_zf     <= (w_done_result == {XLEN{1'b0}});
                r_sf     <= w_done_result[XLEN-1];
                r_cf     <= w_done_cf;
                r_vf     <= w_done_vf;
            end else begin
                r_result <= r_result;
                r_zf     <= r_zf;
                r_sf     <= r_sf;
                r_cf     <= r_cf;
                r_vf     <= r_vf;
            end
        end
    end

    assign o_result = r_result;
    assign o_valid  = r_valid;
    assign o_busy   = r_busy;
    assign o_zf     = r_zf;
    assign o_sf     = r_sf;
    assign o_cf     = r_cf;
    assign o_vf     = r_vf;

endmodule
